// File: rtl/ahb_i2c_slave_if_if.sv
// AHB-Lite bus bundle between the system master and the I2C bridge register slave.
// Latency: none; the interface only groups the signals.
// Backpressure: hreadyout/hready carry the wait-state handshake.
interface ahb_i2c_slave_if_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_i2c_slave_if.sv
// AHB-Lite register slave for the AHB-to-I2C bridge: CTRL, STATUS, TXDATA (FIFO), RXDATA, SADDR.
// Latency: zero wait states; read data is driven in the data phase straight from the registers.
// Backpressure: a TXDATA write to a full FIFO holds hreadyout low until a slot frees; illegal access -> 2-cycle ERROR.
// Optional feature macro AHB_SLV_IRQ_EN adds a registered irq output.
module ahb_i2c_slave_if #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                     Hclk,
    input  logic                     Hreset,
    ahb_i2c_slave_if_if.slave        bus,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [7:0]               i2c_ctrl,
    output logic [6:0]               i2c_saddr,
    input  logic                     i2c_busy,
    input  logic                     i2c_nack
`ifdef AHB_SLV_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int             PW       = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]    FULL_CNT = FIFO_DEPTH[PW:0];
    localparam logic [2:0]     IDX_CTRL  = 3'd0;
    localparam logic [2:0]     IDX_STAT  = 3'd1;
    localparam logic [2:0]     IDX_TX    = 3'd2;
    localparam logic [2:0]     IDX_RX    = 3'd3;
    localparam logic [2:0]     IDX_SADDR = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          r_state, w_next;
    logic [4:0]      r_addr;
    logic            r_write;
    logic [7:0]      r_ctrl;
    logic [6:0]      r_saddr;
    logic [7:0]      r_rx_byte;
    logic            r_rx_full, r_overrun;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PW:0]     r_count;

    logic            w_addr_acc, w_take, w_aligned, w_legal;
    logic            w_in_dphase, w_lane0, w_tx_wr;
    logic            w_tx_full, w_tx_empty, w_pop, w_push_ok, w_push;
    logic            w_wr_ctrl, w_wr_saddr, w_rd_rx, w_rd_status;
    logic            w_ready, w_resp;
    logic [31:0]     w_rdata, w_status;
    logic            w_unused;

    // Address-phase decode: legality is judged on the live address-phase signals.
    assign w_addr_acc = bus.hsel & bus.hready & bus.htrans[1];
    assign w_take     = w_addr_acc & w_ready & (r_state != S_ERR1);
    assign w_aligned  = (bus.hsize == 3'b001) ? ~bus.haddr[0] :
                        (bus.hsize == 3'b010) ? (bus.haddr[1:0] == 2'b00) : 1'b1;
    assign w_legal    = (bus.haddr[31:5] == BASE_ADDR[31:5]) && (bus.haddr[4:2] <= IDX_SADDR) &&
                        (bus.hsize <= 3'b010) && w_aligned;

    // Data-phase decode. Legal accesses are aligned, so byte lane 0 is enabled exactly
    // when the low address bits are zero; every register lives in lane 0.
    assign w_in_dphase = (r_state == S_DATA) || (r_state == S_WAIT);
    assign w_lane0     = (r_addr[1:0] == 2'b00);
    assign w_tx_wr     = w_in_dphase & r_write & (r_addr[4:2] == IDX_TX) & w_lane0;
    assign w_wr_ctrl   = (r_state == S_DATA) & r_write & (r_addr[4:2] == IDX_CTRL) & w_lane0;
    assign w_wr_saddr  = (r_state == S_DATA) & r_write & (r_addr[4:2] == IDX_SADDR) & w_lane0;
    assign w_rd_rx     = (r_state == S_DATA) & ~r_write & (r_addr[4:2] == IDX_RX);
    assign w_rd_status = (r_state == S_DATA) & ~r_write & (r_addr[4:2] == IDX_STAT);

    // TX FIFO handshake: a pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_tx_full  = (r_count == FULL_CNT);
    assign w_tx_empty = (r_count == '0);
    assign w_pop      = ~w_tx_empty & tx_ready;
    assign w_push_ok  = ~w_tx_full | w_pop;
    assign w_push     = w_tx_wr & w_push_ok;
    assign w_status   = {26'b0, r_overrun, r_rx_full, w_tx_full, w_tx_empty, i2c_nack, i2c_busy};

    // FSM state register.
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // FSM next state: stall in WAIT, two-cycle error, otherwise follow the next address phase.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_ERR1:  w_next = S_ERR2;
            default: begin
                if (!w_ready)        w_next = S_WAIT;
                else if (w_take)     w_next = w_legal ? S_DATA : S_ERR1;
                else                 w_next = S_IDLE;
            end
        endcase
    end

    // FSM outputs: wait states, error response and the read-data mux.
    always_comb begin
        w_ready = 1'b1;
        w_resp  = 1'b0;
        w_rdata = '0;
        case (r_state)
            S_DATA, S_WAIT: begin
                if (w_tx_wr && !w_push_ok) w_ready = 1'b0;
                if ((r_state == S_DATA) && !r_write) begin
                    case (r_addr[4:2])
                        IDX_CTRL:  w_rdata = {24'b0, r_ctrl};
                        IDX_STAT:  w_rdata = w_status;
                        IDX_RX:    w_rdata = r_rx_full ? {24'b0, r_rx_byte} : 32'b0;
                        IDX_SADDR: w_rdata = {25'b0, r_saddr};
                        default:   w_rdata = '0;
                    endcase
                end
            end
            S_ERR1: begin
                w_ready = 1'b0;
                w_resp  = 1'b1;
            end
            S_ERR2:  w_resp = 1'b1;
            default: ;
        endcase
    end

    assign bus.hreadyout = w_ready;
    assign bus.hresp     = w_resp;
    assign bus.hrdata    = w_rdata;

    // Address capture and the RW control registers (written at the end of the data phase).
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_ctrl  <= '0;
            r_saddr <= '0;
        end else begin
            if (w_take) begin
                r_addr  <= bus.haddr[4:0];
                r_write <= bus.hwrite;
            end
            if (w_wr_ctrl)  r_ctrl  <= bus.hwdata[7:0];
            if (w_wr_saddr) r_saddr <= bus.hwdata[6:0];
        end
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= bus.hwdata[7:0];
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (PW+1)'(1);
        end
    end

    // RX holding byte with sticky overrun; a new byte always wins over a same-cycle read.
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            r_rx_byte <= '0;
            r_rx_full <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (rx_valid) begin
                r_rx_byte <= rx_data;
                r_rx_full <= 1'b1;
            end else if (w_rd_rx) begin
                r_rx_full <= 1'b0;
            end
            if (rx_valid && r_rx_full) r_overrun <= 1'b1;
            else if (w_rd_status)      r_overrun <= 1'b0;
        end
    end

    assign tx_data   = r_mem[r_rd_ptr];
    assign tx_valid  = ~w_tx_empty;
    assign i2c_ctrl  = r_ctrl;
    assign i2c_saddr = r_saddr;

`ifdef AHB_SLV_IRQ_EN
    // Interrupt: CTRL[7:5] enable rx_full, tx_empty and nack sources.
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) irq <= 1'b0;
        else         irq <= (r_ctrl[7] & r_rx_full) | (r_ctrl[6] & w_tx_empty) | (r_ctrl[5] & i2c_nack);
    end
`endif

    // Burst type and the upper write lanes carry nothing this block stores.
    assign w_unused = ^{1'b0, bus.hburst, bus.hwdata[31:8]};

endmodule

// File: tb/tb_ahb_i2c_slave_if.sv
`timescale 1ns/1ps
module tb_ahb_i2c_slave_if;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 4;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  i2c_ctrl;
    logic [6:0]  i2c_saddr;
    logic        i2c_busy = 1'b0;
    logic        i2c_nack = 1'b0;
`ifdef AHB_SLV_IRQ_EN
    logic        irq;
`endif

    always #5 Hclk = ~Hclk;

    ahb_i2c_slave_if_if bus();
    assign bus.hready = bus.hreadyout;

    ahb_i2c_slave_if #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .bus(bus),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .i2c_ctrl(i2c_ctrl), .i2c_saddr(i2c_saddr),
        .i2c_busy(i2c_busy), .i2c_nack(i2c_nack)
`ifdef AHB_SLV_IRQ_EN
        , .irq(irq)
`endif
    );

    // Reference model: register contents, RX buffer state and the TX byte queue.
    logic [7:0] m_ctrl;
    logic [6:0] m_saddr;
    logic [7:0] m_rx_byte;
    logic       m_rx_full, m_ovr;
    logic [7:0] m_txq[$];
    int         n_chk = 0;
    int         n_bad = 0;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = '0;
        s[0] = i2c_busy;
        s[1] = i2c_nack;
        s[2] = (m_txq.size() == 0);
        s[3] = (m_txq.size() == DEPTH);
        s[4] = m_rx_full;
        s[5] = m_ovr;
        return s;
    endfunction

    function automatic logic [31:0] m_rxdata();
        return m_rx_full ? {24'b0, m_rx_byte} : 32'b0;
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_saddr = '0; m_rx_byte = '0; m_rx_full = 1'b0; m_ovr = 1'b0;
        m_txq.delete();
    endtask

    task automatic bus_idle();
        bus.hsel = 1'b0; bus.htrans = 2'b00; bus.haddr = '0;
        bus.hwrite = 1'b0; bus.hsize = 3'b000; bus.hburst = 3'b000;
    endtask

    task automatic addr_phase(input logic [4:0] off, input logic wr, input logic [2:0] sz);
        @(negedge Hclk);
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = BASE | {27'b0, off};
        bus.hwrite = wr; bus.hsize = sz; bus.hburst = 3'($urandom_range(0, 7));
    endtask

    task automatic data_phase(input logic [31:0] wd, output logic [31:0] rd, output int waits,
                              output logic rf, output logic rl);
        @(negedge Hclk);
        bus_idle();
        bus.hwdata = wd;
        #1;
        waits = 0;
        rf    = bus.hresp;
        while (bus.hreadyout !== 1'b1 && waits < 40) begin
            waits++;
            @(negedge Hclk);
            #1;
        end
        rd = bus.hrdata;
        rl = bus.hresp;
    endtask

    task automatic xfer(input logic [4:0] off, input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits, output logic rf, output logic rl);
        addr_phase(off, wr, sz);
        data_phase(wd, rd, waits, rf, rl);
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge Hclk);
        rx_valid = 1'b1; rx_data = b;
        @(negedge Hclk);
        rx_valid = 1'b0;
        if (m_rx_full) m_ovr = 1'b1;
        m_rx_byte = b; m_rx_full = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int w; logic rf, rl;
        Hreset = 1'b0;
        bus_idle(); bus.hwdata = '0;
        repeat (3) @(negedge Hclk);
        #1;
        n_chk++; if (bus.hreadyout !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout: got %b want 1", bus.hreadyout); end
        n_chk++; if (bus.hresp !== 1'b0) begin n_bad++; $display("FAIL reset_hresp: got %b want 0", bus.hresp); end
        n_chk++; if (bus.hrdata !== 32'h0) begin n_bad++; $display("FAIL reset_hrdata: got %h want 0", bus.hrdata); end
        n_chk++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx: got valid=%b data=%h want 0/00", tx_valid, tx_data); end
        n_chk++; if (i2c_ctrl !== 8'h00 || i2c_saddr !== 7'h00) begin n_bad++; $display("FAIL reset_regs: got ctrl=%h saddr=%h want 0/0", i2c_ctrl, i2c_saddr); end
        @(negedge Hclk);
        Hreset = 1'b1;
        model_reset();
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== 32'h0000_0004) begin n_bad++; $display("FAIL reset_status: got %h want 00000004", rd); end
    endtask

    task automatic test_regs();
        logic [31:0] rd, wd; int w; logic rf, rl; logic [4:0] off; logic [2:0] sz;
        for (int i = 0; i < 8; i++) begin
            wd = (i == 0) ? 32'h0000_00A5 : $urandom;
            xfer(5'h00, 1'b1, 3'b010, wd, rd, w, rf, rl);
            m_ctrl = wd[7:0];
            n_chk++; if (w !== 0 || rl !== 1'b0) begin n_bad++; $display("FAIL ctrl_write_resp: got waits=%0d resp=%b want 0/0", w, rl); end
            wd = (i == 0) ? 32'h0000_0050 : $urandom;
            xfer(5'h10, 1'b1, 3'b010, wd, rd, w, rf, rl);
            m_saddr = wd[6:0];
            xfer(5'h00, 1'b0, 3'b010, '0, rd, w, rf, rl);
            n_chk++; if (rd !== {24'b0, m_ctrl} || w !== 0 || rl !== 1'b0) begin n_bad++; $display("FAIL ctrl_read: got %h waits=%0d resp=%b want %h", rd, w, rl, {24'b0, m_ctrl}); end
            xfer(5'h10, 1'b0, 3'b010, '0, rd, w, rf, rl);
            n_chk++; if (rd !== {25'b0, m_saddr} || w !== 0 || rl !== 1'b0) begin n_bad++; $display("FAIL saddr_read: got %h waits=%0d resp=%b want %h", rd, w, rl, {25'b0, m_saddr}); end
            n_chk++; if (i2c_ctrl !== m_ctrl || i2c_saddr !== m_saddr) begin n_bad++; $display("FAIL reg_outputs: got %h/%h want %h/%h", i2c_ctrl, i2c_saddr, m_ctrl, m_saddr); end
        end
        // Sub-word writes only touch CTRL when byte lane 0 is among the enabled lanes.
        for (int i = 0; i < 8; i++) begin
            sz  = 3'($urandom_range(0, 2));
            off = (sz == 3'd0) ? 5'($urandom_range(0, 3)) : (sz == 3'd1) ? 5'(2 * $urandom_range(0, 1)) : 5'h00;
            wd  = $urandom;
            xfer(off, 1'b1, sz, wd, rd, w, rf, rl);
            if (off == 5'h00) m_ctrl = wd[7:0];
            xfer(5'h00, 1'b0, 3'b010, '0, rd, w, rf, rl);
            n_chk++; if (rd !== {24'b0, m_ctrl}) begin n_bad++; $display("FAIL ctrl_lanes off=%0d sz=%0d: got %h want %h", off, sz, rd, {24'b0, m_ctrl}); end
        end
        // Read-only and write-only registers.
        xfer(5'h04, 1'b1, 3'b010, 32'hFFFF_FFFF, rd, w, rf, rl);
        n_chk++; if (w !== 0 || rl !== 1'b0) begin n_bad++; $display("FAIL ro_write_resp: got waits=%0d resp=%b want 0/0", w, rl); end
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== m_status()) begin n_bad++; $display("FAIL ro_write_status: got %h want %h", rd, m_status()); end
        xfer(5'h08, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== 32'h0 || tx_valid !== 1'b0) begin n_bad++; $display("FAIL txdata_read: got %h valid=%b want 0/0", rd, tx_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; int w; logic rf, rl;
        logic [4:0] offs [8] = '{5'h18, 5'h02, 5'h14, 5'h1C, 5'h00, 5'h01, 5'h11, 5'h00};
        logic       wrs  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0] szs  [8] = '{3'd2, 3'd2, 3'd0, 3'd2, 3'd3, 3'd1, 3'd1, 3'd4};
        for (int i = 0; i < 12; i++) begin
            if (i < 8) xfer(offs[i], wrs[i], szs[i], $urandom, rd, w, rf, rl);
            else       xfer(5'($urandom_range(20, 31)), 1'($urandom), 3'($urandom_range(0, 2)), $urandom, rd, w, rf, rl);
            n_chk++; if (w !== 1 || rf !== 1'b1 || rl !== 1'b1) begin n_bad++; $display("FAIL error_resp case %0d: got waits=%0d resp=%b,%b want 1 wait, 1,1", i, w, rf, rl); end
            xfer(5'h00, 1'b0, 3'b010, '0, rd, w, rf, rl);
            n_chk++; if (w !== 0 || rl !== 1'b0 || rd !== {24'b0, m_ctrl}) begin n_bad++; $display("FAIL after_error case %0d: got %h waits=%0d resp=%b want %h", i, rd, w, rl, {24'b0, m_ctrl}); end
        end
    endtask

    task automatic test_tx_fifo();
        logic [31:0] rd; int w; logic rf, rl; logic [7:0] e;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            xfer(5'h08, 1'b1, 3'b010, 32'h11 + i, rd, w, rf, rl);
            m_txq.push_back(8'(8'h11 + i));
            n_chk++; if (w !== 0 || rl !== 1'b0) begin n_bad++; $display("FAIL tx_push_%0d: got waits=%0d resp=%b want 0/0", i, w, rl); end
        end
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== m_status()) begin n_bad++; $display("FAIL tx_full_status: got %h want %h", rd, m_status()); end
        addr_phase(5'h08, 1'b1, 3'b010);
        @(negedge Hclk); bus_idle(); bus.hwdata = 32'h15; #1;
        n_chk++; if (bus.hreadyout !== 1'b0) begin n_bad++; $display("FAIL tx_stall_1: got hreadyout=%b want 0", bus.hreadyout); end
        @(negedge Hclk); #1;
        n_chk++; if (bus.hreadyout !== 1'b0) begin n_bad++; $display("FAIL tx_stall_2: got hreadyout=%b want 0", bus.hreadyout); end
        @(negedge Hclk); tx_ready = 1'b1; #1;
        e = m_txq.pop_front();
        m_txq.push_back(8'h15);
        n_chk++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || tx_data !== e) begin n_bad++; $display("FAIL tx_pop_push: got rdy=%b resp=%b head=%h want 1/0/%h", bus.hreadyout, bus.hresp, tx_data, e); end
        @(negedge Hclk); tx_ready = 1'b0;
        @(negedge Hclk); tx_ready = 1'b1;
        while (m_txq.size() > 0) begin
            #1;
            e = m_txq.pop_front();
            n_chk++; if (tx_valid !== 1'b1 || tx_data !== e) begin n_bad++; $display("FAIL tx_drain: got valid=%b data=%h want 1/%h", tx_valid, tx_data, e); end
            @(negedge Hclk);
        end
        tx_ready = 1'b0; #1;
        n_chk++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_empty_after_drain: got valid=%b want 0", tx_valid); end
    endtask

    task automatic test_tx_random();
        logic [31:0] rd, wd; int w, n; logic rf, rl; logic [7:0] e;
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                wd = $urandom;
                xfer(5'h08, 1'b1, 3'b010, wd, rd, w, rf, rl);
                m_txq.push_back(wd[7:0]);
            end
            xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
            n_chk++; if (rd !== m_status()) begin n_bad++; $display("FAIL tx_rand_status: got %h want %h", rd, m_status()); end
            @(negedge Hclk); tx_ready = 1'b1;
            while (m_txq.size() > 0) begin
                #1;
                e = m_txq.pop_front();
                n_chk++; if (tx_valid !== 1'b1 || tx_data !== e) begin n_bad++; $display("FAIL tx_rand_drain: got valid=%b data=%h want 1/%h", tx_valid, tx_data, e); end
                @(negedge Hclk);
            end
            tx_ready = 1'b0;
        end
    endtask

    task automatic test_rx();
        logic [31:0] rd; int w; logic rf, rl; int op;
        i2c_busy = 1'b0; i2c_nack = 1'b0;
        rx_pulse(8'h3C);
        rx_pulse(8'h7E);
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== m_status() || rd[5:4] !== 2'b11) begin n_bad++; $display("FAIL rx_overrun_status: got %h want %h", rd, m_status()); end
        m_ovr = 1'b0;
        xfer(5'h0C, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== 32'h0000_007E) begin n_bad++; $display("FAIL rx_read: got %h want 0000007e", rd); end
        m_rx_full = 1'b0;
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== m_status() || rd[5] !== 1'b0) begin n_bad++; $display("FAIL rx_overrun_cleared: got %h want %h", rd, m_status()); end
        xfer(5'h0C, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== 32'h0 || rl !== 1'b0) begin n_bad++; $display("FAIL rx_read_empty: got %h resp=%b want 0/0", rd, rl); end
        for (int i = 0; i < 24; i++) begin
            i2c_busy = 1'($urandom); i2c_nack = 1'($urandom);
            op = $urandom_range(0, 2);
            if (op == 0) rx_pulse(8'($urandom));
            else if (op == 1) begin
                xfer(5'h0C, 1'b0, 3'b010, '0, rd, w, rf, rl);
                n_chk++; if (rd !== m_rxdata()) begin n_bad++; $display("FAIL rx_rand_data: got %h want %h", rd, m_rxdata()); end
                m_rx_full = 1'b0;
            end else begin
                xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
                n_chk++; if (rd !== m_status()) begin n_bad++; $display("FAIL rx_rand_status: got %h want %h", rd, m_status()); end
                m_ovr = 1'b0;
            end
        end
        i2c_busy = 1'b0; i2c_nack = 1'b0;
    endtask

    task automatic test_rx_same_cycle();
        logic [31:0] rd; int w; logic rf, rl;
        xfer(5'h0C, 1'b0, 3'b010, '0, rd, w, rf, rl);
        m_rx_full = 1'b0;
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        m_ovr = 1'b0;
        rx_pulse(8'h42);
        addr_phase(5'h0C, 1'b0, 3'b010);
        @(negedge Hclk); bus_idle(); rx_valid = 1'b1; rx_data = 8'h99; #1;
        n_chk++; if (bus.hrdata !== 32'h0000_0042 || bus.hreadyout !== 1'b1) begin n_bad++; $display("FAIL rx_same_cycle_data: got %h rdy=%b want 00000042/1", bus.hrdata, bus.hreadyout); end
        @(negedge Hclk); rx_valid = 1'b0;
        m_ovr = 1'b1; m_rx_byte = 8'h99; m_rx_full = 1'b1;
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== m_status() || rd[4] !== 1'b1) begin n_bad++; $display("FAIL rx_same_cycle_full: got %h want %h", rd, m_status()); end
        m_ovr = 1'b0;
        xfer(5'h0C, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== 32'h0000_0099) begin n_bad++; $display("FAIL rx_same_cycle_next: got %h want 00000099", rd); end
        m_rx_full = 1'b0;
        // STATUS read racing a fresh overrun keeps the overrun flag.
        rx_pulse(8'h10);
        addr_phase(5'h04, 1'b0, 3'b010);
        @(negedge Hclk); bus_idle(); rx_valid = 1'b1; rx_data = 8'h20; #1;
        n_chk++; if (bus.hrdata !== m_status()) begin n_bad++; $display("FAIL status_race_data: got %h want %h", bus.hrdata, m_status()); end
        @(negedge Hclk); rx_valid = 1'b0;
        m_ovr = 1'b1; m_rx_byte = 8'h20;
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== m_status() || rd[5] !== 1'b1) begin n_bad++; $display("FAIL status_race_sticky: got %h want %h", rd, m_status()); end
        m_ovr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd;
        for (int i = 0; i < 4; i++) begin
            wd = $urandom;
            addr_phase(5'h00, 1'b1, 3'b010);
            @(negedge Hclk);
            bus.hsel = 1'b1; bus.htrans = 2'b10; bus.haddr = BASE; bus.hwrite = 1'b0; bus.hsize = 3'b010;
            bus.hwdata = wd; #1;
            n_chk++; if (bus.hreadyout !== 1'b1) begin n_bad++; $display("FAIL b2b_write_ready: got %b want 1", bus.hreadyout); end
            m_ctrl = wd[7:0];
            @(negedge Hclk); bus_idle(); #1;
            n_chk++; if (bus.hrdata !== {24'b0, m_ctrl} || bus.hresp !== 1'b0) begin n_bad++; $display("FAIL b2b_read: got %h resp=%b want %h", bus.hrdata, bus.hresp, {24'b0, m_ctrl}); end
        end
        addr_phase(5'h1C, 1'b0, 3'b010);
        @(negedge Hclk); bus_idle();
        @(negedge Hclk);
        bus.hsel = 1'b1; bus.htrans = 2'b11; bus.haddr = BASE | 32'h10; bus.hwrite = 1'b0; bus.hsize = 3'b010; #1;
        n_chk++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b1) begin n_bad++; $display("FAIL b2b_err2: got rdy=%b resp=%b want 1/1", bus.hreadyout, bus.hresp); end
        @(negedge Hclk); bus_idle(); #1;
        n_chk++; if (bus.hrdata !== {25'b0, m_saddr} || bus.hresp !== 1'b0) begin n_bad++; $display("FAIL b2b_after_err: got %h resp=%b want %h", bus.hrdata, bus.hresp, {25'b0, m_saddr}); end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd, wd; int w; logic rf, rl;
        wd = 32'h80 | 32'($urandom_range(0, 127));
        xfer(5'h00, 1'b1, 3'b010, wd, rd, w, rf, rl);
        m_ctrl = wd[7:0];
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) xfer(5'h08, 1'b1, 3'b010, $urandom, rd, w, rf, rl);
        addr_phase(5'h08, 1'b1, 3'b010);
        @(negedge Hclk); bus_idle(); bus.hwdata = 32'h15; #1;
        n_chk++; if (bus.hreadyout !== 1'b0) begin n_bad++; $display("FAIL rstwait_stall: got %b want 0", bus.hreadyout); end
        @(negedge Hclk); Hreset = 1'b0; #1;
        n_chk++; if (bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0 || tx_valid !== 1'b0 || i2c_ctrl !== 8'h00) begin n_bad++; $display("FAIL rstwait_state: got rdy=%b resp=%b valid=%b ctrl=%h want 1/0/0/00", bus.hreadyout, bus.hresp, tx_valid, i2c_ctrl); end
        @(negedge Hclk); Hreset = 1'b1;
        model_reset();
        xfer(5'h04, 1'b0, 3'b010, '0, rd, w, rf, rl);
        n_chk++; if (rd !== 32'h0000_0004) begin n_bad++; $display("FAIL rstwait_status: got %h want 00000004", rd); end
    endtask

    initial begin
        model_reset();
        bus_idle();
        bus.hwdata = '0;
        #2;
        test_reset();
        test_regs();
        test_errors();
        test_tx_fifo();
        test_tx_random();
        test_rx();
        test_rx_same_cycle();
        test_back_to_back();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached after %0d comparisons", n_chk);
        $fatal(1, "watchdog");
    end
endmodule
